game_round_ctrl: RTL
====================

Name: game_round_ctrl

Overview:
Round sequencer for the binary number game; sits between the player inputs and the seconds Timer.
- Each round it picks a nonzero 8-bit target and loads the Timer with the current round time.
- It judges the player's submitted guess, tracks score and lives, and shortens the round time as the player succeeds.
- It ends the game on win (ROUNDS correct answers) or loss (lives exhausted).

Parameters:
ROUNDS, 10, correct answers needed to win (1..15)
LIVES, 3, lives at game start (1..7)
START_TIME, 20, first round time in seconds (1..31)
MIN_TIME, 5, floor for round time in seconds (1..START_TIME)
TIME_STEP, 1, seconds removed from round time per correct answer
HOLD_CYCLES, 50000000, clk cycles the RESULT state is held

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse, debounced start button
submit  in  1  single-cycle pulse, debounced submit button
guess  in  8  player switch value, sampled on submit
timer_end  in  1  end_f from Timer
timer_load  out  1  drives Timer time_f
timer_value  out  5  drives Timer time_v (round time)
target  out  8  number the player must enter
score  out  10  correct answers (bonus-weighted if enabled)
lives  out  3  remaining lives
round_no  out  4  correct answers so far
playing  out  1  high in PLAY
correct  out  1  level, high in RESULT after a correct guess
wrong  out  1  level, high in RESULT after a wrong guess or timeout
win  out  1  level, high in DONE after winning
game_over  out  1  level, high in DONE after losing

Behaviour:
- Reset (async, rst_n low):
  - State is IDLE.
  - All outputs are 0, except lives=LIVES and timer_value=START_TIME.
  - LFSR=8'hA5.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clk in every state. It is never 0, so target is never 0.
- IDLE: on start go to GEN. Reload score=0, lives=LIVES, round_no=0, round_time=START_TIME.
- GEN, 1 cycle: target <= LFSR; go to LOAD.
- LOAD, 1 cycle:
  - timer_load=1 and timer_value=round_time; go to PLAY.
  - The Timer clears end_f on the same edge, so timer_end is valid from the first PLAY cycle.
- PLAY: playing=1. Priority order:
  1. submit with guess==target: score+1, round_no+1; round_time=max(round_time-TIME_STEP, MIN_TIME), computed without underflow; correct=1; go to RESULT.
  2. submit with guess!=target: lives-1; wrong=1; go to RESULT.
  3. timer_end=1 with no submit: lives-1; wrong=1; go to RESULT.
  - Submit and timer_end in the same cycle: submit wins.
- RESULT:
  - Counts HOLD_CYCLES cycles. submit and start are ignored.
  - On expiry: if round_no==ROUNDS go to DONE with win=1; else if lives==0 go to DONE with game_over=1; else go to GEN.
  - correct and wrong clear on exit.
- DONE: holds score, win and game_over. start behaves as in IDLE.
- start outside IDLE and DONE is ignored. submit outside PLAY is ignored.
- timer_load is high for exactly one cycle per round, never in any other state.
- The timer keeps running after a submit; its later end_f is ignored because the state is no longer PLAY.
- rst_n asserted mid-round returns to IDLE immediately. The Timer is not reset by this block and its stale end_f is ignored.

Optional Feature:
TIME_BONUS_EN
- Defined:
  - Adds input timeleft (5 bits, from the Timer).
  - A correct guess adds 1+timeleft to score, using the value sampled on the submit cycle.
  - score saturates at 1023.
- Undefined: the port is absent and a correct guess adds 1.

Decomposition:
- Shared package: state enum (IDLE, GEN, LOAD, PLAY, RESULT, DONE), LFSR seed and tap constants, target/score/time widths.
- Sub-module lfsr8: enable=1, seed on reset, 8-bit out. Reused later for other random features.

Test Plan:
Use HOLD_CYCLES=4, START_TIME=3, MIN_TIME=2, ROUNDS=2, LIVES=2. Drive timer_end from the bench.
1. rst_n low mid-PLAY -> next cycle: IDLE, outputs zero, lives=2, timer_value=3; timer_load never pulses until start.
2. start; submit guess=target in PLAY -> correct=1 for 4 cycles; score=1, round_no=1; next LOAD has timer_value=2 and a 1-cycle timer_load.
3. Second correct guess -> round_time stays 2 (floor); after RESULT, DONE with win=1, score=2.
4. New game; submit guess=target^1 -> wrong=1, lives=1; then timer_end=1 -> lives=0, DONE with game_over=1.
5. submit (correct) and timer_end in the same PLAY cycle -> counted correct, lives unchanged.
6. TIME_BONUS_EN defined, timeleft=7 on a correct submit -> score increases by 8; preload score near 1023 -> saturates at 1023.

Source files
------------

// File: rtl/game_round_ctrl_pkg.sv
// Shared types and constants for the binary number game round sequencer.
package game_round_ctrl_pkg;

  localparam int unsigned TargetW = 8;
  localparam int unsigned ScoreW  = 10;
  localparam int unsigned LivesW  = 3;
  localparam int unsigned RoundW  = 4;
  localparam int unsigned TimeW   = 5;

  localparam logic [7:0] LfsrSeed = 8'hA5;
  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LfsrTaps = 8'b1011_1000;

  typedef enum logic [2:0] {
    StIdle,
    StGen,
    StLoad,
    StPlay,
    StResult,
    StDone
  } state_e;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LfsrTaps)};
  endfunction

endpackage

// File: rtl/game_round_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR; seeded on reset so the output is never zero.
module game_round_ctrl_lfsr8
  import game_round_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] value
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LfsrSeed;
    end else if (en) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: picks targets, loads the Timer, judges guesses, tracks score and lives.
// Optional TIME_BONUS_EN adds a timeleft input and a time-weighted, saturating score.
module game_round_ctrl
  import game_round_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS      = 10,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned START_TIME  = 20,
  parameter int unsigned MIN_TIME    = 5,
  parameter int unsigned TIME_STEP   = 1,
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               submit,
  input  logic [TargetW-1:0] guess,
  input  logic               timer_end,
`ifdef TIME_BONUS_EN
  input  logic [TimeW-1:0]   timeleft,
`endif
  output logic               timer_load,
  output logic [TimeW-1:0]   timer_value,
  output logic [TargetW-1:0] target,
  output logic [ScoreW-1:0]  score,
  output logic [LivesW-1:0]  lives,
  output logic [RoundW-1:0]  round_no,
  output logic               playing,
  output logic               correct,
  output logic               wrong,
  output logic               win,
  output logic               game_over
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned DecFloor = MIN_TIME + TIME_STEP;

  state_e             state_q, state_d;
  logic [TargetW-1:0] target_q, target_d;
  logic [ScoreW-1:0]  score_q, score_d, score_inc;
  logic [LivesW-1:0]  lives_q, lives_d;
  logic [RoundW-1:0]  round_q, round_d;
  logic [TimeW-1:0]   round_time_q, round_time_d, time_dec;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic               correct_q, correct_d;
  logic               wrong_q, wrong_d;
  logic               win_q, win_d;
  logic               over_q, over_d;
  logic [TargetW-1:0] lfsr_value;

  game_round_ctrl_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .value (lfsr_value)
  );

`ifdef TIME_BONUS_EN
  logic [ScoreW:0] bonus_sum;
  assign bonus_sum = {1'b0, score_q} + {{(ScoreW - TimeW + 1){1'b0}}, timeleft}
                   + {{ScoreW{1'b0}}, 1'b1};
  assign score_inc = bonus_sum[ScoreW] ? '1 : bonus_sum[ScoreW-1:0];
`else
  assign score_inc = score_q + {{(ScoreW - 1){1'b0}}, 1'b1};
`endif

  // Shrink round time but never below the floor, without underflow.
  always_comb begin
    if (32'(round_time_q) >= DecFloor) begin
      time_dec = round_time_q - TimeW'(TIME_STEP);
    end else begin
      time_dec = TimeW'(MIN_TIME);
    end
  end

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    score_d      = score_q;
    lives_d      = lives_q;
    round_d      = round_q;
    round_time_d = round_time_q;
    hold_d       = hold_q;
    correct_d    = correct_q;
    wrong_d      = wrong_q;
    win_d        = win_q;
    over_d       = over_q;
    timer_load   = 1'b0;
    playing      = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StGen;
          score_d      = '0;
          lives_d      = LivesW'(LIVES);
          round_d      = '0;
          round_time_d = TimeW'(START_TIME);
          win_d        = 1'b0;
          over_d       = 1'b0;
        end
      end
      StGen: begin
        target_d = lfsr_value;
        state_d  = StLoad;
      end
      StLoad: begin
        timer_load = 1'b1;
        state_d    = StPlay;
      end
      StPlay: begin
        playing = 1'b1;
        hold_d  = '0;
        if (submit && (guess == target_q)) begin
          score_d      = score_inc;
          round_d      = round_q + 4'd1;
          round_time_d = time_dec;
          correct_d    = 1'b1;
          state_d      = StResult;
        end else if (submit || timer_end) begin
          lives_d = (lives_q != '0) ? lives_q - 3'd1 : '0;
          wrong_d = 1'b1;
          state_d = StResult;
        end
      end
      StResult: begin
        if (hold_q == HoldW'(HOLD_CYCLES - 1)) begin
          correct_d = 1'b0;
          wrong_d   = 1'b0;
          if (round_q == RoundW'(ROUNDS)) begin
            win_d   = 1'b1;
            state_d = StDone;
          end else if (lives_q == '0) begin
            over_d  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StGen;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      target_q     <= '0;
      score_q      <= '0;
      lives_q      <= LivesW'(LIVES);
      round_q      <= '0;
      round_time_q <= TimeW'(START_TIME);
      hold_q       <= '0;
      correct_q    <= 1'b0;
      wrong_q      <= 1'b0;
      win_q        <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      round_q      <= round_d;
      round_time_q <= round_time_d;
      hold_q       <= hold_d;
      correct_q    <= correct_d;
      wrong_q      <= wrong_d;
      win_q        <= win_d;
      over_q       <= over_d;
    end
  end

  assign timer_value = round_time_q;
  assign target      = target_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign round_no    = round_q;
  assign correct     = correct_q;
  assign wrong       = wrong_q;
  assign win         = win_q;
  assign game_over   = over_q;

endmodule
